// File: rtl/onehot_decoder_reg.sv
// Registered one-hot to index decoder with valid/ready handshakes on both sides.
// Malformed words (two or more bits set) are decoded as index 0, flagged on
// err_out, and counted in a saturating error counter.
`timescale 1ns/1ps

module onehot_decoder_reg #(
  parameter int unsigned USE_GRAY  = 0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           onehot_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           code_out,
  output logic                 err_out,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 clr_err
);

  localparam int unsigned IN_W   = 7;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned POP_W  = 3;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              accept;
  logic              pop;
  logic [POP_W-1:0]  pop_cnt;
  logic [CODE_W-1:0] dec_idx;
  logic [CODE_W-1:0] dec_code;
  logic              dec_err;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  // Handshake qualifiers; the output slot frees up in the same cycle it is popped.
  always_comb begin
    in_ready = (state_q == EMPTY) || out_ready;
    accept   = in_valid && in_ready;
    pop      = (state_q == FULL) && out_ready;
  end

  // Output slot occupancy: fill on accept, drain on pop without a refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (pop && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  assign out_valid = (state_q == FULL);

  // Population count and position decode of the incoming word.
  always_comb begin
    pop_cnt = '0;
    dec_idx = '0;
    for (int unsigned k = 0; k < IN_W; k++) begin
      pop_cnt = pop_cnt + POP_W'(onehot_in[k]);
      if (onehot_in[k]) dec_idx = CODE_W'(k + 1);
    end
  end

  // Final code: malformed words force index 0; optional Gray mapping.
  always_comb begin
    dec_err  = (pop_cnt >= POP_W'(2));
    dec_code = '0;
    if (!dec_err) begin
      if (USE_GRAY != 0) dec_code = dec_idx ^ (dec_idx >> 1);
      else               dec_code = dec_idx;
    end
  end

  // Output payload register; loads only on accept so it holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_out <= '0;
      err_out  <= 1'b0;
    end else if (accept) begin
      code_out <= dec_code;
      err_out  <= dec_err;
    end
  end

  // Error count next value: clear first, then a saturating increment per malformed accept.
  always_comb begin
    err_cnt_d = err_cnt;
    if (clr_err) err_cnt_d = '0;
    if (accept && dec_err && (err_cnt_d != CNT_MAX)) err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= err_cnt_d;
  end

endmodule
